// File: rtl/usb_sie_regs.sv
// CPU register block for a USB serial interface engine: TX/RX byte FIFOs and status.
// Define USB_SIE_REGS_IRQ_EN to build the interrupt enables and the irq output.
module usb_sie_regs #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] din,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_eop,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

    typedef enum logic {IDLE, SEND} tx_state_t;

    logic        sel;
    logic [11:0] offset;
    logic        wr_tx_data, wr_tx_ctrl, wr_rx_ctrl, rd_rx_data;

    assign sel        = (addr[15:12] == 4'h6);
    assign offset     = addr[11:0];
    assign wr_tx_data = wr && sel && (offset == 12'h000);
    assign wr_tx_ctrl = wr && sel && (offset == 12'h002);
    assign wr_rx_ctrl = wr && sel && (offset == 12'h006);
    assign rd_rx_data = rd && sel && (offset == 12'h004);

    // ---------------- TX path ----------------
    tx_state_t       tx_state;
    logic [7:0]      tx_mem [FIFO_DEPTH];
    logic [AW-1:0]   tx_wr_ptr, tx_rd_ptr;
    logic [4:0]      tx_count;
    logic            tx_done, tx_done_nxt;
    logic            tx_full, tx_empty, tx_push, tx_pop, tx_start, tx_done_clr;

    assign tx_full     = (tx_count == DEPTH_CNT);
    assign tx_empty    = (tx_count == 5'd0);
    assign tx_push     = wr_tx_data && (tx_state == IDLE) && !tx_full;
    assign tx_pop      = (tx_state == SEND) && tx_ready;
    assign tx_start    = wr_tx_ctrl && din[0] && (tx_state == IDLE) && !tx_empty;
    assign tx_done_clr = wr_tx_ctrl && din[1];

    // Popping the final byte must win over a same-cycle clear so the event is never lost.
    always_comb begin
        tx_done_nxt = tx_done;
        if (tx_pop && (tx_count == 5'd1))
            tx_done_nxt = 1'b1;
        else if (tx_done_clr)
            tx_done_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= IDLE;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= 5'd0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= tx_done_nxt;
            case (tx_state)
                IDLE: begin
                    if (tx_push) begin
                        tx_wr_ptr <= tx_wr_ptr + 1'b1;
                        tx_count  <= tx_count + 5'd1;
                    end
                    if (tx_start)
                        tx_state <= SEND;
                end
                SEND: begin
                    if (tx_pop) begin
                        tx_rd_ptr <= tx_rd_ptr + 1'b1;
                        tx_count  <= tx_count - 5'd1;
                        if (tx_count == 5'd1)
                            tx_state <= IDLE;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= din[7:0];
    end

    // Pushes are blocked in SEND, so the head byte and count cannot move under backpressure.
    assign tx_valid = (tx_state == SEND);
    assign tx_data  = tx_mem[tx_rd_ptr];
    assign tx_last  = (tx_state == SEND) && (tx_count == 5'd1);

    // ---------------- RX path ----------------
    logic [7:0]      rx_mem [FIFO_DEPTH];
    logic [AW-1:0]   rx_wr_ptr, rx_rd_ptr;
    logic [4:0]      rx_count;
    logic            rx_done, rx_done_nxt, rx_overflow, rx_overflow_nxt;
    logic            rx_full, rx_empty, rx_push, rx_pop, rx_flush, rx_clr, rx_ovf_set;

    assign rx_full    = (rx_count == DEPTH_CNT);
    assign rx_empty   = (rx_count == 5'd0);
    assign rx_pop     = rd_rx_data && !rx_empty;
    assign rx_flush   = wr_rx_ctrl && din[1];
    assign rx_clr     = wr_rx_ctrl && din[0];
    assign rx_push    = rx_valid && (!rx_full || rx_pop) && !rx_flush;
    assign rx_ovf_set = rx_valid && rx_full && !rx_pop && !rx_flush;

    always_comb begin
        rx_done_nxt     = rx_done;
        rx_overflow_nxt = rx_overflow;
        if (rx_eop)
            rx_done_nxt = 1'b1;
        else if (rx_clr)
            rx_done_nxt = 1'b0;
        if (rx_ovf_set)
            rx_overflow_nxt = 1'b1;
        else if (rx_clr)
            rx_overflow_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_count    <= 5'd0;
            rx_done     <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            rx_done     <= rx_done_nxt;
            rx_overflow <= rx_overflow_nxt;
            if (rx_flush) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
                rx_count  <= 5'd0;
            end else begin
                if (rx_push)
                    rx_wr_ptr <= rx_wr_ptr + 1'b1;
                if (rx_pop)
                    rx_rd_ptr <= rx_rd_ptr + 1'b1;
                if (rx_push && !rx_pop)
                    rx_count <= rx_count + 5'd1;
                else if (rx_pop && !rx_push)
                    rx_count <= rx_count - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr] <= rx_data;
    end

    // ---------------- Interrupts ----------------
    logic tx_irq_en_rd, rx_irq_en_rd;

`ifdef USB_SIE_REGS_IRQ_EN
    logic tx_irq_en, rx_irq_en, tx_irq_en_nxt, rx_irq_en_nxt;

    assign tx_irq_en_nxt = wr_tx_ctrl ? din[15] : tx_irq_en;
    assign rx_irq_en_nxt = wr_rx_ctrl ? din[15] : rx_irq_en;

    // irq is computed from next-state values so it lines up with the flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_irq_en <= 1'b0;
            rx_irq_en <= 1'b0;
            irq       <= 1'b0;
        end else begin
            tx_irq_en <= tx_irq_en_nxt;
            rx_irq_en <= rx_irq_en_nxt;
            irq       <= (tx_done_nxt && tx_irq_en_nxt) || (rx_done_nxt && rx_irq_en_nxt);
        end
    end

    assign tx_irq_en_rd = tx_irq_en;
    assign rx_irq_en_rd = rx_irq_en;
`else
    assign irq          = 1'b0;
    assign tx_irq_en_rd = 1'b0;
    assign rx_irq_en_rd = 1'b0;
`endif

    logic unused_din_bits;
    assign unused_din_bits = ^din[15:8];

    // ---------------- CPU read path ----------------
    logic [15:0] rd_value;

    always_comb begin
        rd_value = 16'h0000;
        if (sel) begin
            case (offset)
                12'h002: rd_value = {tx_irq_en_rd, 6'b0, tx_count, tx_done, tx_empty, tx_full,
                                     (tx_state == SEND)};
                12'h004: rd_value = {8'h00, rx_empty ? 8'h00 : rx_mem[rx_rd_ptr]};
                12'h006: rd_value = {rx_irq_en_rd, 6'b0, rx_count, 1'b0, rx_empty, rx_overflow,
                                     rx_done};
                default: rd_value = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            dout <= 16'h0000;
        else
            dout <= (rd && sel) ? rd_value : 16'h0000;
    end

endmodule
